// File: rtl/etapa_if.sv
// etapa_if: instruction-fetch stage feeding decode through the IF/ID register.
// Latency: a fetched word shows on instruccion the cycle after imem_ready=1.
// Backpressure: stall holds IF/ID; a word caught during stall waits in a one-entry buffer.
// Optional: define ETAPA_IF_CONT_EN to add saturating cnt_instr / cnt_stall outputs.

module etapa_if #(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 14,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               salto,
  input  logic [PC_W-1:0]    dir_salto,
  output logic               imem_rd,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instruccion,
  output logic [PC_W-1:0]    pc_out,
  output logic               valido
`ifdef ETAPA_IF_CONT_EN
  ,
  output logic [15:0]        cnt_instr,
  output logic [15:0]        cnt_stall
`endif
);

  // FETCH: a request is outstanding on the memory port.
  // WAIT : a word arrived while decode was stalled and sits in the buffer.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_nxt;

  // One-entry buffer; it is occupied exactly when state == WAIT.
  logic [INSTR_W-1:0] buf_dat;
  logic [INSTR_W-1:0] buf_dat_nxt;
  logic [PC_W-1:0]    buf_pc;
  logic [PC_W-1:0]    buf_pc_nxt;

  // IF/ID register next values.
  logic [INSTR_W-1:0] instr_nxt;
  logic [PC_W-1:0]    pc_out_nxt;
  logic               valido_nxt;

  // High in cycles where the IF/ID register is loaded with a real instruction.
  logic               load_ifid;

  logic [PC_W-1:0]    pc_inc;

  // Sequential PC increment; wraps naturally at 2^PC_W.
  assign pc_inc = pc + PC_W'(1);

  // The memory address always follows the PC; stable while a request is pending.
  assign imem_addr = pc;

  // Request memory only in FETCH, and never during the reset cycle.
  assign imem_rd = (state == FETCH) && !reset;

  // State and datapath registers; reset returns to an empty pipeline at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      buf_dat     <= '0;
      buf_pc      <= '0;
      instruccion <= '0;
      pc_out      <= '0;
      valido      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      buf_dat     <= buf_dat_nxt;
      buf_pc      <= buf_pc_nxt;
      instruccion <= instr_nxt;
      pc_out      <= pc_out_nxt;
      valido      <= valido_nxt;
    end
  end

  // Next-state and datapath decisions; redirect beats stall, stall beats fetch.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    buf_dat_nxt = buf_dat;
    buf_pc_nxt  = buf_pc;
    instr_nxt   = instruccion;
    pc_out_nxt  = pc_out;
    valido_nxt  = valido;
    load_ifid   = 1'b0;

    if (salto) begin
      // Redirect: drop any returning word and any buffered word, refetch at target.
      pc_nxt     = dir_salto;
      valido_nxt = 1'b0;
      state_nxt  = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            pc_nxt = pc_inc;
            if (stall) begin
              // Decode cannot take it now; park the word with its address.
              buf_dat_nxt = imem_data;
              buf_pc_nxt  = pc;
              state_nxt   = WAIT;
            end else begin
              instr_nxt  = imem_data;
              pc_out_nxt = pc;
              valido_nxt = 1'b1;
              load_ifid  = 1'b1;
            end
          end else if (!stall) begin
            // Memory still busy: hand decode a bubble, keep the stale payload.
            valido_nxt = 1'b0;
          end
        end
        WAIT: begin
          if (!stall) begin
            instr_nxt  = buf_dat;
            pc_out_nxt = buf_pc;
            valido_nxt = 1'b1;
            load_ifid  = 1'b1;
            state_nxt  = FETCH;
          end
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

`ifdef ETAPA_IF_CONT_EN
  logic [15:0] cnt_instr_q;
  logic [15:0] cnt_stall_q;

  assign cnt_instr = cnt_instr_q;
  assign cnt_stall = cnt_stall_q;

  // Saturating count of instructions handed to decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_instr_q <= '0;
    end else if (load_ifid && (cnt_instr_q != 16'hFFFF)) begin
      cnt_instr_q <= cnt_instr_q + 16'd1;
    end
  end

  // Saturating count of cycles with stall asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_stall_q <= '0;
    end else if (stall && (cnt_stall_q != 16'hFFFF)) begin
      cnt_stall_q <= cnt_stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_etapa_if.sv
// Bench for etapa_if: directed per-cycle vector table plus a random stall/ready run
// checked against an in-order delivery scoreboard.
module tb_etapa_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        salto;
  logic [9:0]  dir_salto;
  logic        imem_rd;
  logic [9:0]  imem_addr;
  logic [13:0] imem_data;
  logic        imem_ready;
  logic [13:0] instruccion;
  logic [9:0]  pc_out;
  logic        valido;
`ifdef ETAPA_IF_CONT_EN
  logic [15:0] cnt_instr;
  logic [15:0] cnt_stall;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory contents: word at address a is 0x11*(a+1), truncated to 14 bits.
  function automatic logic [13:0] mw(input logic [9:0] a);
    logic [13:0] t;
    t = 14'(a) + 14'd1;
    return 14'(t * 14'h0011);
  endfunction

  assign imem_data = mw(imem_addr);

  etapa_if #(.PC_W(10), .INSTR_W(14), .RESET_PC(10'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .salto       (salto),
    .dir_salto   (dir_salto),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_ready  (imem_ready),
    .instruccion (instruccion),
    .pc_out      (pc_out),
    .valido      (valido)
`ifdef ETAPA_IF_CONT_EN
    ,
    .cnt_instr   (cnt_instr),
    .cnt_stall   (cnt_stall)
`endif
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        sal;
    logic [9:0]  dir;
    logic        rdy;
    logic        e_rd;
    logic        c_addr;
    logic [9:0]  e_addr;
    logic        e_vld;
    logic        c_dat;
    logic [13:0] e_ins;
    logic [9:0]  e_pc;
  } vec_t;

  function automatic vec_t mk(input logic rst, stl, sal, input logic [9:0] dir, input logic rdy,
                              input logic e_rd, c_addr, input logic [9:0] e_addr,
                              input logic e_vld, c_dat, input logic [13:0] e_ins,
                              input logic [9:0] e_pc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.sal = sal; v.dir = dir; v.rdy = rdy;
    v.e_rd = e_rd; v.c_addr = c_addr; v.e_addr = e_addr;
    v.e_vld = e_vld; v.c_dat = c_dat; v.e_ins = e_ins; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t tv[30];

  initial begin
    int exp_pc;
    logic s;

    reset = 1'b1; stall = 1'b0; salto = 1'b0; dir_salto = '0; imem_ready = 1'b0;

    //          rst stl sal dir     rdy  rd ca addr     vld cd ins        pc
    tv[0]  = mk(1, 0, 0, 10'h000, 0,   0, 0, 10'h000, 0, 1, 14'h0,     10'h000);
    // back-to-back single-cycle memory
    tv[1]  = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h000, 1, 1, mw(10'h000), 10'h000);
    tv[2]  = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h001, 1, 1, mw(10'h001), 10'h001);
    tv[3]  = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h002, 1, 1, mw(10'h002), 10'h002);
    tv[4]  = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h003, 1, 1, mw(10'h003), 10'h003);
    // slow memory: two bubbles, address held
    tv[5]  = mk(0, 0, 0, 10'h000, 0,   1, 1, 10'h004, 0, 0, 14'h0,     10'h000);
    tv[6]  = mk(0, 0, 0, 10'h000, 0,   1, 1, 10'h004, 0, 0, 14'h0,     10'h000);
    tv[7]  = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h004, 1, 1, mw(10'h004), 10'h004);
    // stall 4 cycles while addr 5 returns
    tv[8]  = mk(0, 1, 0, 10'h000, 1,   1, 1, 10'h005, 1, 1, mw(10'h004), 10'h004);
    tv[9]  = mk(0, 1, 0, 10'h000, 0,   0, 1, 10'h006, 1, 1, mw(10'h004), 10'h004);
    tv[10] = mk(0, 1, 0, 10'h000, 0,   0, 1, 10'h006, 1, 1, mw(10'h004), 10'h004);
    tv[11] = mk(0, 1, 0, 10'h000, 0,   0, 1, 10'h006, 1, 1, mw(10'h004), 10'h004);
    tv[12] = mk(0, 0, 0, 10'h000, 0,   0, 1, 10'h006, 1, 1, mw(10'h005), 10'h005);
    tv[13] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h006, 1, 1, mw(10'h006), 10'h006);
    // branch with stall and ready in the same cycle
    tv[14] = mk(0, 1, 1, 10'h200, 1,   1, 1, 10'h007, 0, 0, 14'h0,     10'h000);
    tv[15] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h200, 1, 1, mw(10'h200), 10'h200);
    // PC wrap
    tv[16] = mk(0, 0, 1, 10'h3FE, 0,   1, 1, 10'h201, 0, 0, 14'h0,     10'h000);
    tv[17] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h3FE, 1, 1, mw(10'h3FE), 10'h3FE);
    tv[18] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h3FF, 1, 1, mw(10'h3FF), 10'h3FF);
    tv[19] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h000, 1, 1, mw(10'h000), 10'h000);
    // reset while a word is buffered in WAIT
    tv[20] = mk(0, 1, 0, 10'h000, 1,   1, 1, 10'h001, 1, 1, mw(10'h000), 10'h000);
    tv[21] = mk(1, 1, 0, 10'h000, 0,   0, 1, 10'h002, 0, 1, 14'h0,     10'h000);
    tv[22] = mk(0, 0, 0, 10'h000, 0,   1, 1, 10'h000, 0, 0, 14'h0,     10'h000);
    tv[23] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h000, 1, 1, mw(10'h000), 10'h000);
    // branch while in WAIT discards the buffer
    tv[24] = mk(0, 1, 0, 10'h000, 1,   1, 1, 10'h001, 1, 1, mw(10'h000), 10'h000);
    tv[25] = mk(0, 0, 1, 10'h010, 0,   0, 1, 10'h002, 0, 0, 14'h0,     10'h000);
    tv[26] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h010, 1, 1, mw(10'h010), 10'h010);
    // reset mid-request drops the returning word
    tv[27] = mk(0, 0, 0, 10'h000, 0,   1, 1, 10'h011, 0, 0, 14'h0,     10'h000);
    tv[28] = mk(1, 0, 0, 10'h000, 1,   0, 1, 10'h011, 0, 1, 14'h0,     10'h000);
    tv[29] = mk(0, 0, 0, 10'h000, 1,   1, 1, 10'h000, 1, 1, mw(10'h000), 10'h000);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reset = tv[i].rst; stall = tv[i].stl; salto = tv[i].sal;
      dir_salto = tv[i].dir; imem_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d imem_rd", i), 32'(imem_rd), 32'(tv[i].e_rd));
      if (tv[i].c_addr) chk($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(tv[i].e_addr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valido", i), 32'(valido), 32'(tv[i].e_vld));
      if (tv[i].c_dat) begin
        chk($sformatf("v%0d instruccion", i), 32'(instruccion), 32'(tv[i].e_ins));
        chk($sformatf("v%0d pc_out", i), 32'(pc_out), 32'(tv[i].e_pc));
      end
`ifdef ETAPA_IF_CONT_EN
      if (i == 0 || i == 21) begin
        chk($sformatf("v%0d cnt_instr", i), 32'(cnt_instr), 32'd0);
        chk($sformatf("v%0d cnt_stall", i), 32'(cnt_stall), 32'd0);
      end
      if (i == 13) begin
        chk("cnt_instr after stall run", 32'(cnt_instr), 32'd7);
        chk("cnt_stall after stall run", 32'(cnt_stall), 32'd4);
      end
`endif
    end

    // Random stall/ready run: every new delivery must be the next address in order.
    exp_pc = 1;
    salto = 1'b0; reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      s = stall;
      @(posedge clk);
      #1;
      if (!s && valido) begin
        chk($sformatf("rnd%0d pc_out", k), 32'(pc_out), 32'(exp_pc));
        chk($sformatf("rnd%0d instruccion", k), 32'(instruccion), 32'(mw(10'(exp_pc))));
        exp_pc++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
